// File: rtl/fb_kbd_if.sv
// fb_kbd_if: Firebird MMIO bus bundle for the PS/2 keyboard controller.
//   cs     - register select
//   we     - 1 = write, 0 = read (qualified by cs)
//   addr   - 0 = STATUS, 1 = DATA
//   wdata  - write data
//   rdata  - registered read data
//   rvalid - one-cycle pulse, one clk after an accepted read
//   irq    - level interrupt, high while scan codes are buffered
// master = CPU side, slave = controller side.
interface fb_kbd_if;
  logic        cs;
  logic        we;
  logic        addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;

  modport master (output cs, we, addr, wdata, input rdata, rvalid, irq);
  modport slave  (input cs, we, addr, wdata, output rdata, rvalid, irq);
endinterface

// File: rtl/fb_kbd_ctrl.sv
// fb_kbd_ctrl: PS/2 keyboard controller for the Firebird MMIO space.
// Deserialises PS/2 frames (start, 8 data LSB-first, odd parity, stop) into
// scan-code bytes, buffers them in a FIFO and exposes a STATUS/DATA register
// pair with sticky error flags (OVF, PERR, FERR).
// Ports:
//   clk      - system clock, all state on posedge
//   rst_n    - asynchronous active-low reset
//   ps2_clk  - raw PS/2 clock pin (asynchronous)
//   ps2_data - raw PS/2 data pin (asynchronous)
//   bus      - MMIO slave port (cs/we/addr/wdata in, rdata/rvalid/irq out)
// STATUS word: [15:8] count, [3] OVF, [2] PERR, [1] FERR, [0] data available.
module fb_kbd_ctrl #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    ps2_clk,
  input  logic    ps2_data,
  fb_kbd_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMO_W = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  function automatic logic parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  // ---------------------------------------------------------------- sync stage
  logic clk_p0, sync_clk, sync_clk_d;
  logic dat_p0, sync_data;
  logic fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_p0     <= 1'b1;
      sync_clk   <= 1'b1;
      sync_clk_d <= 1'b1;
      dat_p0     <= 1'b1;
      sync_data  <= 1'b1;
    end else begin
      clk_p0     <= ps2_clk;
      sync_clk   <= clk_p0;
      sync_clk_d <= sync_clk;
      dat_p0     <= ps2_data;
      sync_data  <= dat_p0;
    end
  end

  assign fall = sync_clk_d & ~sync_clk;

  // ----------------------------------------------------------- frame FSM stage
  state_t            state, state_next;
  logic [2:0]        bitcnt;
  logic [7:0]        shreg;
  logic              par_bit;
  logic [TMO_W-1:0]  tcnt;
  logic              push, set_perr, set_ferr, timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    set_perr   = 1'b0;
    set_ferr   = 1'b0;
    // Timeout counts only between falls of an in-progress frame.
    timeout    = (state != IDLE) && !fall && (tcnt == TMO_W'(TIMEOUT - 1));
    if (timeout) begin
      state_next = IDLE;
      set_ferr   = 1'b1;
    end else if (fall) begin
      case (state)
        IDLE:   if (!sync_data) state_next = DATA;
        DATA:   if (bitcnt == 3'd7) state_next = PARITY;
        PARITY: state_next = STOP;
        STOP: begin
          state_next = IDLE;
          if (!sync_data) set_ferr = 1'b1;
          if (!parity_ok(shreg, par_bit)) set_perr = 1'b1;
          push = sync_data && parity_ok(shreg, par_bit);
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitcnt <= '0;
      tcnt   <= '0;
    end else begin
      if (fall && state == IDLE)      bitcnt <= '0;
      else if (fall && state == DATA) bitcnt <= bitcnt + 3'd1;
      if (state == IDLE || fall || timeout) tcnt <= '0;
      else                                  tcnt <= tcnt + TMO_W'(1);
    end
  end

  // Frame payload is pure data; a stale partial byte is overwritten by the
  // next frame's eight shifts, so it needs no reset or explicit discard.
  always_ff @(posedge clk) begin
    if (fall && state == DATA)   shreg   <= {sync_data, shreg[7:1]};
    if (fall && state == PARITY) par_bit <= sync_data;
  end

  // --------------------------------------------------------- FIFO / MMIO stage
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [PTR_W:0]   count, count_next;
  logic             rd_req, wr_req, pop, full, push_ok, ovf_set;
  logic             ovf, perr, ferr;
  logic [2:0]       clr;
  logic [7:0]       cnt8;
  logic [31:0]      status;
  logic             unused_wdata;

  assign rd_req     = bus.cs & ~bus.we;
  assign wr_req     = bus.cs & bus.we;
  assign pop        = rd_req & bus.addr & (count != '0);
  assign full       = (count == (PTR_W+1)'(FIFO_DEPTH));
  // A pop on the same edge frees the slot, so a full FIFO still accepts it.
  assign push_ok    = push & (~full | pop);
  assign ovf_set    = push & full & ~pop;
  assign count_next = count + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop};
  assign clr        = (wr_req && !bus.addr) ? bus.wdata[3:1] : 3'b000;
  assign cnt8       = 8'(count);
  assign status     = {16'h0000, cnt8, 4'h0, ovf, perr, ferr, (count != '0)};
  assign unused_wdata = ^{bus.wdata[31:4], bus.wdata[0]};

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      ovf        <= 1'b0;
      perr       <= 1'b0;
      ferr       <= 1'b0;
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
      bus.irq    <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + PTR_W'(1);
      if (pop)     rptr <= rptr + PTR_W'(1);
      count <= count_next;
      // Setting a flag wins over a same-cycle write-1-to-clear.
      ovf  <= (ovf  & ~clr[2]) | ovf_set;
      perr <= (perr & ~clr[1]) | set_perr;
      ferr <= (ferr & ~clr[0]) | set_ferr;
      bus.rvalid <= rd_req;
      if (rd_req) begin
        if (!bus.addr)         bus.rdata <= status;
        else if (count != '0)  bus.rdata <= {24'h000000, mem[rptr]};
        else                   bus.rdata <= '0;
      end
      bus.irq <= (count_next != '0);
    end
  end

endmodule

// File: tb/tb_fb_kbd_ctrl.sv
module tb_fb_kbd_ctrl;
  localparam int DEPTH = 8;
  localparam int TMO   = 200;
  localparam int H     = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  fb_kbd_if bus();

  fb_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // Reference model: byte queue plus three sticky flags.
  logic [7:0] q[$];
  logic m_ovf = 1'b0, m_perr = 1'b0, m_ferr = 1'b0;

  function automatic logic [31:0] m_status();
    return {16'h0000, 8'(q.size()), 4'h0, m_ovf, m_perr, m_ferr, (q.size() != 0)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_partial(input logic [7:0] d, input int nbits);
    ps2_bit(1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(d[i]);
    @(negedge clk);
    ps2_data = 1'b1;
  endtask

  // Sends one frame; optionally lands a DATA read on the exact push edge
  // (pin fall + 3 clk) and checks what it returns.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                            input bit rd_at_push);
    logic [31:0] exp_rd;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit((~^d) ^ bad_par);
    @(negedge clk);
    ps2_data = ~bad_stop;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    if (rd_at_push) begin
      exp_rd = (q.size() > 0) ? {24'h0, q.pop_front()} : 32'h0;
      @(negedge clk);
      @(negedge clk);
      bus.cs = 1'b1; bus.we = 1'b0; bus.addr = 1'b1;
      @(negedge clk);
      bus.cs = 1'b0;
      check("rd_at_push_data", bus.rdata, exp_rd);
      repeat (H - 3) @(negedge clk);
    end else begin
      repeat (H) @(negedge clk);
    end
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
    ps2_data = 1'b1;
    if (bad_stop) m_ferr = 1'b1;
    if (bad_par)  m_perr = 1'b1;
    if (!bad_stop && !bad_par) begin
      if (q.size() < DEPTH) q.push_back(d);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic do_read(input logic a, output logic [31:0] r, output logic v);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
    @(negedge clk);
    bus.cs = 1'b0;
    r = bus.rdata;
    v = bus.rvalid;
  endtask

  task automatic do_write(input logic a, input logic [31:0] wd);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = wd;
    @(negedge clk);
    bus.cs = 1'b0; bus.we = 1'b0;
    if (!a) begin
      if (wd[3]) m_ovf  = 1'b0;
      if (wd[2]) m_perr = 1'b0;
      if (wd[1]) m_ferr = 1'b0;
    end
  endtask

  task automatic check_status(input string tag, input logic [31:0] exp);
    logic [31:0] r;
    logic v;
    do_read(1'b0, r, v);
    check(tag, r, exp);
  endtask

  task automatic check_data_read(input string tag);
    logic [31:0] r, exp;
    logic v;
    exp = (q.size() > 0) ? {24'h0, q.pop_front()} : 32'h0;
    do_read(1'b1, r, v);
    check(tag, r, exp);
    check({tag, "_rvalid"}, {31'h0, v}, 32'h1);
  endtask

  initial begin
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 1'b0; bus.wdata = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rdata", bus.rdata, 32'h0);
    check("rst_rvalid", {31'h0, bus.rvalid}, 32'h0);
    check("rst_irq", {31'h0, bus.irq}, 32'h0);
    rst_n = 1'b1;

    // 1. Reset mid-frame, then a clean frame
    send_partial(8'h1C, 4);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check_status("t1_status_after_rst", 32'h0000_0000);
    send_frame(8'h1C, 0, 0, 0);
    check_status("t1_status_frame", 32'h0000_0101);
    check_data_read("t1_data");

    // 2. Good frame 0x1C
    send_frame(8'h1C, 0, 0, 0);
    check("t2_irq_set", {31'h0, bus.irq}, 32'h1);
    check_status("t2_status", 32'h0000_0101);
    check_data_read("t2_data");
    check("t2_irq_clr", {31'h0, bus.irq}, 32'h0);
    @(negedge clk);
    check("t2_rvalid_pulse", {31'h0, bus.rvalid}, 32'h0);
    check_status("t2_status_empty", 32'h0000_0000);

    // 3. Parity error, then W1C
    send_frame(8'h1C, 1, 0, 0);
    check_status("t3_perr", 32'h0000_0004);
    do_write(1'b0, 32'h0000_0004);
    check_status("t3_cleared", 32'h0000_0000);

    // 4. Nine frames into an eight-entry FIFO
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 0, 0);
    check_status("t4_full_ovf", 32'h0000_0809);
    do_write(1'b1, 32'hFFFF_FFFF);
    check_status("t4_data_write_ignored", 32'h0000_0809);
    for (int i = 1; i <= 9; i++) check_data_read($sformatf("t4_data%0d", i));
    do_write(1'b0, 32'h0000_0008);
    check_status("t4_ovf_cleared", 32'h0000_0000);

    // 5. Timeout on a partial frame
    send_partial(8'hA5, 5);
    repeat (TMO + 20) @(negedge clk);
    m_ferr = 1'b1;
    check_status("t5_ferr", 32'h0000_0002);
    do_write(1'b0, 32'h0000_0002);
    send_frame(8'hF0, 0, 0, 0);
    check_status("t5_after", 32'h0000_0101);
    check_data_read("t5_data");

    // Stop-bit error
    send_frame(8'h3C, 0, 1, 0);
    check_status("stop_ferr", 32'h0000_0002);
    do_write(1'b0, 32'h0000_000E);

    // 6. Full FIFO, pop and push on the same edge
    for (int i = 0; i < 8; i++) send_frame(8'(8'h30 + i), 0, 0, 0);
    send_frame(8'h38, 0, 0, 1);
    check_status("t6_no_ovf", 32'h0000_0801);
    for (int i = 0; i < 8; i++) check_data_read($sformatf("t6_data%0d", i));
    check_status("t6_empty", m_status());

    // Randomised traffic against the model
    for (int it = 0; it < 40; it++) begin
      logic [7:0] d;
      int r;
      d = 8'($urandom);
      r = $urandom_range(0, 15);
      send_frame(d, r == 0, r == 1, 0);
      if ($urandom_range(0, 2) == 0) check_status($sformatf("rnd_status%0d", it), m_status());
      for (int k = 0; k < $urandom_range(0, 2); k++) begin
        check_data_read($sformatf("rnd_data%0d_%0d", it, k));
        check($sformatf("rnd_irq%0d_%0d", it, k), {31'h0, bus.irq}, {31'h0, (q.size() != 0)});
      end
      if ($urandom_range(0, 4) == 0) do_write(1'b0, $urandom);
    end
    check_status("rnd_final_status", m_status());
    while (q.size() > 0) check_data_read("rnd_drain");
    check_status("rnd_drained", m_status());

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
